// File: rtl/wb_sdram_bridge.sv
// Wishbone classic slave to SDRAM controller bridge.
// Bursts sequential Wishbone writes into the controller's write FIFO and
// streams sequential reads out of its read FIFO; any break in sequence
// closes the current SDRAM command, which is then followed by a drain
// (writes) and a restart gap before the next command is opened.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wbs_*               Wishbone classic slave (32-bit data, word address)
//   sdram_ready         controller initialised; low forces IDLE
//   app_write_enable    write command enable (held through drain)
//   app_read_enable     read command enable
//   app_address         burst start word address
//   app_write_pulse     one-cycle push of app_write_data/app_write_mask
//   write_fifo_full     controller write FIFO full
//   app_read_pulse      one-cycle pop; app_read_data valid the next cycle
//   read_fifo_empty     controller read FIFO empty
module wb_sdram_bridge #(
  parameter int unsigned DRAIN_CYCLES = 32,
  parameter int unsigned RESTART_GAP  = 4,
  parameter int unsigned READ_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  input  logic        sdram_ready,
  output logic        app_write_enable,
  output logic        app_read_enable,
  output logic [21:0] app_address,
  output logic        app_write_pulse,
  output logic [31:0] app_write_data,
  output logic [3:0]  app_write_mask,
  input  logic        write_fifo_full,
  output logic        app_read_pulse,
  input  logic [31:0] app_read_data,
  input  logic        read_fifo_empty
);

  localparam int unsigned MAX_DG = (DRAIN_CYCLES > RESTART_GAP) ? DRAIN_CYCLES : RESTART_GAP;
  localparam int unsigned MAX_C  = (MAX_DG > READ_TIMEOUT) ? MAX_DG : READ_TIMEOUT;
  localparam int unsigned CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(RESTART_GAP - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(READ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRITE_DRAIN,
    READ_WAIT,
    READ_POP,
    READ_CAPTURE,
    GAP
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [21:0] expected_q, expected_d;
  logic        first_q, first_d;

  logic [31:0] dat_d;
  logic        ack_d, err_d;
  logic        wen_d, ren_d;
  logic [21:0] addr_d;
  logic        wpulse_d, rpulse_d;
  logic [31:0] wdata_d;
  logic [3:0]  wmask_d;

  logic        req;
  logic [21:0] adr22;
  logic        addr_match;
  logic        unused_adr;

  assign req        = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
  assign adr22      = wbs_adr_i[21:0];
  assign addr_match = (adr22 == expected_q);
  assign unused_adr = ^wbs_adr_i[31:22];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      expected_q       <= '0;
      first_q          <= 1'b0;
      wbs_dat_o        <= '0;
      wbs_ack_o        <= 1'b0;
      wbs_err_o        <= 1'b0;
      app_write_enable <= 1'b0;
      app_read_enable  <= 1'b0;
      app_address      <= '0;
      app_write_pulse  <= 1'b0;
      app_write_data   <= '0;
      app_write_mask   <= '0;
      app_read_pulse   <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      expected_q       <= expected_d;
      first_q          <= first_d;
      wbs_dat_o        <= dat_d;
      wbs_ack_o        <= ack_d;
      wbs_err_o        <= err_d;
      app_write_enable <= wen_d;
      app_read_enable  <= ren_d;
      app_address      <= addr_d;
      app_write_pulse  <= wpulse_d;
      app_write_data   <= wdata_d;
      app_write_mask   <= wmask_d;
      app_read_pulse   <= rpulse_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    expected_d = expected_q;
    first_d    = first_q;
    dat_d      = wbs_dat_o;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    wen_d      = app_write_enable;
    ren_d      = app_read_enable;
    addr_d     = app_address;
    wpulse_d   = 1'b0;
    wdata_d    = app_write_data;
    wmask_d    = app_write_mask;
    rpulse_d   = 1'b0;

    if (!sdram_ready) begin
      state_d = IDLE;
      cnt_d   = '0;
      wen_d   = 1'b0;
      ren_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_d = adr22;
            cnt_d  = '0;
            if (wbs_we_i) begin
              expected_d = adr22 + 22'd1;
              first_d    = 1'b1;
              wen_d      = 1'b1;
              state_d    = WRITE;
            end else begin
              expected_d = adr22;
              ren_d      = 1'b1;
              state_d    = READ_WAIT;
            end
          end
        end

        WRITE: begin
          if (!wbs_cyc_i || (req && (!wbs_we_i || !(first_q || addr_match)))) begin
            state_d = WRITE_DRAIN;
            cnt_d   = '0;
          end else if (req && !write_fifo_full) begin
            // The opening request already set expected to adr+1, so every
            // push simply re-derives it from the accepted address.
            wpulse_d   = 1'b1;
            wdata_d    = wbs_dat_i;
            wmask_d    = ~wbs_sel_i;
            ack_d      = 1'b1;
            expected_d = adr22 + 22'd1;
            first_d    = 1'b0;
          end
        end

        WRITE_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            wen_d   = 1'b0;
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        GAP: begin
          wen_d = 1'b0;
          ren_d = 1'b0;
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        READ_WAIT: begin
          if (!wbs_cyc_i || (req && (wbs_we_i || !addr_match))) begin
            ren_d   = 1'b0;
            cnt_d   = '0;
            state_d = GAP;
          end else if (!read_fifo_empty) begin
            rpulse_d = 1'b1;
            cnt_d    = '0;
            state_d  = READ_POP;
          end else if (cnt_q == TO_LAST) begin
            err_d   = 1'b1;
            ren_d   = 1'b0;
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        READ_POP: begin
          state_d = READ_CAPTURE;
        end

        READ_CAPTURE: begin
          cnt_d = '0;
          if (req && !wbs_we_i && addr_match) begin
            dat_d      = app_read_data;
            ack_d      = 1'b1;
            expected_d = expected_q + 22'd1;
            state_d    = READ_WAIT;
          end else begin
            ren_d   = 1'b0;
            state_d = GAP;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Scoreboard bench for wb_sdram_bridge: stimulus pushes expected pushes,
// responses and command addresses into queues; a negedge monitor pops and
// compares them whenever the DUT presents the matching output.
module tb_wb_sdram_bridge;

  localparam int unsigned DRAIN   = 32;
  localparam int unsigned GAPC    = 4;
  localparam int unsigned TIMEOUT = 1024;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic [31:0] dat_o;
  logic        ack, err;
  logic        sdram_ready;
  logic        wen, ren;
  logic [21:0] app_address;
  logic        wpulse;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        full;
  logic        rpulse;
  logic [31:0] rdata = '0;
  logic        empty = 1'b1;

  wb_sdram_bridge #(
    .DRAIN_CYCLES(DRAIN),
    .RESTART_GAP (GAPC),
    .READ_TIMEOUT(TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wbs_cyc_i       (cyc),
    .wbs_stb_i       (stb),
    .wbs_we_i        (we),
    .wbs_sel_i       (sel),
    .wbs_adr_i       (adr),
    .wbs_dat_i       (dat_i),
    .wbs_dat_o       (dat_o),
    .wbs_ack_o       (ack),
    .wbs_err_o       (err),
    .sdram_ready     (sdram_ready),
    .app_write_enable(wen),
    .app_read_enable (ren),
    .app_address     (app_address),
    .app_write_pulse (wpulse),
    .app_write_data  (wdata),
    .app_write_mask  (wmask),
    .write_fifo_full (full),
    .app_read_pulse  (rpulse),
    .app_read_data   (rdata),
    .read_fifo_empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 write ack, 1 read ack, 2 error
    logic [31:0] data;
  } resp_t;

  resp_t       ackq[$];
  logic [35:0] wq[$];
  logic [21:0] addrq[$];
  logic [31:0] fifo_mem[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller read FIFO model: pop on app_read_pulse, data next cycle.
  always @(posedge clk) begin
    if (rpulse && fifo_mem.size() > 0) rdata <= fifo_mem.pop_front();
  end
  always @(negedge clk) empty = (fifo_mem.size() == 0);

  // Monitor
  logic prev_en = 1'b0;
  logic had_cmd = 1'b0;
  int   low_run = 0;
  always @(negedge clk) begin
    resp_t       e;
    logic [35:0] w;
    if (rst) begin
      prev_en = 1'b0;
      had_cmd = 1'b0;
      low_run = 0;
    end else begin
      if (wpulse) begin
        if (wq.size() == 0) chk("unexpected_push", 1, 0);
        else begin
          w = wq.pop_front();
          chk("push_data", 64'(wdata), 64'(w[35:4]));
          chk("push_mask", 64'(wmask), 64'(w[3:0]));
        end
      end
      if (ack || err) begin
        if (ackq.size() == 0) chk("unexpected_resp", {ack, err}, 0);
        else begin
          e = ackq.pop_front();
          chk("resp_kind", {ack, err}, (e.kind == 2) ? 2'b01 : 2'b10);
          if (e.kind == 1) chk("read_data", 64'(dat_o), 64'(e.data));
          if (e.kind == 0) chk("ack_with_push", wpulse, 1);
          if (e.kind == 2) chk("err_clears_ren", ren, 0);
        end
      end
      if ((wen || ren) && !prev_en) begin
        if (addrq.size() == 0) chk("unexpected_cmd", 1, 0);
        else chk("cmd_address", 64'(app_address), 64'(addrq.pop_front()));
        if (had_cmd) chk("restart_gap", 64'(low_run >= int'(GAPC)), 1);
        had_cmd = 1'b1;
        low_run = 0;
      end
      if (!(wen || ren)) low_run++;
      prev_en = wen || ren;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
  endtask

  task automatic end_cyc();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_resp(input int limit, output int cycles);
    logic got;
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (ack || err) got = 1'b1;
    end
    chk("resp_seen", got, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((wen || ren) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("returns_idle", {wen, ren}, 0);
    tick(GAPC + 2);
  endtask

  task automatic exp_write(input logic [31:0] d, input logic [3:0] s);
    resp_t r;
    r.kind = 0; r.data = '0;
    ackq.push_back(r);
    wq.push_back({d, ~s});
  endtask

  task automatic exp_resp(input int k, input logic [31:0] d);
    resp_t r;
    r.kind = k; r.data = d;
    ackq.push_back(r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc_n, hi, lo, n;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_i = '0;
    sdram_ready = 1'b1; full = 1'b0;
    tick(3);
    chk("rst_ack_err",  {ack, err}, 0);
    chk("rst_dat_o",    64'(dat_o), 0);
    chk("rst_enables",  {wen, ren, wpulse, rpulse}, 0);
    chk("rst_address",  64'(app_address), 0);
    chk("rst_wdata",    64'(wdata), 0);
    chk("rst_wmask",    64'(wmask), 0);
    rst = 1'b0;
    tick(2);

    // Three sequential writes, then drain and gap timing.
    addrq.push_back(22'h10);
    for (int i = 0; i < 3; i++) begin
      exp_write(32'h1000_0000 + 32'(i), 4'hF);
      req(1'b1, 32'h10 + 32'(i), 32'h1000_0000 + 32'(i), 4'hF);
      wait_resp(50, cyc_n);
    end
    end_cyc();
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!wen) break;
      hi++;
    end
    chk("drain_len", 64'(hi), 64'(DRAIN));
    lo = 1;
    repeat (GAPC - 1) begin
      @(negedge clk);
      if (!wen && !ren) lo++;
    end
    chk("gap_low", 64'(lo), 64'(GAPC));
    tick(3);

    // Non-sequential write in the same cycle restarts the burst.
    addrq.push_back(22'h10);
    exp_write(32'h1111_0000, 4'h3);
    req(1'b1, 32'h10, 32'h1111_0000, 4'h3);
    wait_resp(50, cyc_n);
    addrq.push_back(22'h20);
    exp_write(32'h2222_0000, 4'h5);
    req(1'b1, 32'h20, 32'h2222_0000, 4'h5);
    wait_resp(200, cyc_n);
    chk("late_ack", 64'(cyc_n > int'(DRAIN + GAPC)), 1);
    end_cyc();
    wait_idle();

    // Write FIFO full stall.
    full = 1'b1;
    addrq.push_back(22'h40);
    exp_write(32'hDEAD_BEEF, 4'hF);
    req(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack || wpulse) n++;
    end
    chk("stall_no_ack", 64'(n), 0);
    full = 1'b0;
    wait_resp(5, cyc_n);
    chk("ack_after_full", 64'(cyc_n <= 2), 1);
    end_cyc();
    wait_idle();

    // Full release coinciding with cyc drop: no push.
    full = 1'b1;
    addrq.push_back(22'h80);
    req(1'b1, 32'h80, 32'h8080_8080, 4'hF);
    tick(3);
    full = 1'b0;
    end_cyc();
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack || wpulse) n++;
    end
    chk("drop_wins", 64'(n), 0);
    wait_idle();

    // Two reads across the 22-bit address wrap.
    fifo_mem.push_back(32'hA5A5_A5A5);
    fifo_mem.push_back(32'h5A5A_5A5A);
    addrq.push_back(22'h3F_FFFF);
    exp_resp(1, 32'hA5A5_A5A5);
    req(1'b0, 32'h003F_FFFF, '0, 4'hF);
    wait_resp(50, cyc_n);
    exp_resp(1, 32'h5A5A_5A5A);
    req(1'b0, 32'h0040_0000, '0, 4'hF);
    wait_resp(50, cyc_n);
    end_cyc();
    wait_idle();
    chk("fifo_drained", 64'(fifo_mem.size()), 0);

    // Read timeout with an empty FIFO.
    addrq.push_back(22'h100);
    exp_resp(2, '0);
    req(1'b0, 32'h100, '0, 4'hF);
    wait_resp(TIMEOUT + 20, cyc_n);
    chk("timeout_window", 64'(cyc_n >= int'(TIMEOUT)), 1);
    end_cyc();
    wait_idle();

    // Reset in the middle of a stalled write.
    full = 1'b1;
    addrq.push_back(22'h200);
    req(1'b1, 32'h200, 32'h0200_0200, 4'hF);
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("rst_mid_outputs", {wen, ren, ack, wpulse}, 0);
    rst = 1'b0;
    full = 1'b0;
    end_cyc();
    tick(5);

    // Controller not ready holds a pending write.
    sdram_ready = 1'b0;
    addrq.push_back(22'h300);
    exp_write(32'hCAFE_F00D, 4'hF);
    req(1'b1, 32'h300, 32'hCAFE_F00D, 4'hF);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack || wen || ren) n++;
    end
    chk("not_ready_idle", 64'(n), 0);
    sdram_ready = 1'b1;
    wait_resp(10, cyc_n);
    end_cyc();
    wait_idle();

    chk("ackq_empty",  64'(ackq.size()), 0);
    chk("wq_empty",    64'(wq.size()), 0);
    chk("addrq_empty", 64'(addrq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sdram_bridge.md
WB_SDRAM_BRIDGE -- requirements
Module: wb_sdram_bridge

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 32: cycles app_write_enable stays high after the last write push.
REQ-002 SHALL have parameter RESTART_GAP, default 4: cycles both enables stay low between SDRAM commands.
REQ-003 SHALL have parameter READ_TIMEOUT, default 1024: maximum wait cycles for read data.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave cycle, strobe and write-enable.
REQ-007 wbs_sel_i  input  4  byte selects.
REQ-008 wbs_adr_i  input  32  32-bit word address; only bits [21:0] are used.
REQ-009 wbs_dat_i  input  32; wbs_dat_o  output  32  write data and read data.
REQ-010 wbs_ack_o, wbs_err_o  output  1 each  transfer acknowledge and transfer error.
REQ-011 sdram_ready  input  1  controller initialised.
REQ-012 app_write_enable, app_read_enable  output  1 each  controller command enables.
REQ-013 app_address  output  22  burst start word address.
REQ-014 app_write_pulse  output  1; app_write_data  output  32; app_write_mask  output  4 (1 = byte masked).
REQ-015 write_fifo_full  input  1.
REQ-016 app_read_pulse  output  1; app_read_data  input  32 (valid the cycle after app_read_pulse); read_fifo_empty  input  1.

Function
REQ-017 SHALL implement states IDLE, WRITE, WRITE_DRAIN, READ_WAIT, READ_POP, READ_CAPTURE, GAP.
REQ-018 All outputs SHALL be registered; wbs_ack_o, wbs_err_o, app_write_pulse and app_read_pulse SHALL be single-cycle pulses.
REQ-019 A request is cyc&stb&~ack&~err; while sdram_ready=0 the block SHALL stay in IDLE and SHALL NOT ack.
REQ-020 IDLE with a write request: app_address<=adr[21:0], expected<=adr+1 (22-bit wrap 3FFFFF->000000), app_write_enable<=1, go WRITE without acking.
REQ-021 WRITE with a write request, adr[21:0]==expected or first transfer, and write_fifo_full=0: next cycle app_write_pulse=1, app_write_data=dat_i, app_write_mask=~sel_i, wbs_ack_o=1, expected+=1.
REQ-022 WRITE with write_fifo_full=1: the block SHALL stall without acking or pushing until the FIFO is not full.
REQ-023 WRITE with cyc=0, a non-sequential address, or a read request: go WRITE_DRAIN (no ack); the pending request is served after GAP.
REQ-024 WRITE_DRAIN SHALL hold app_write_enable=1 for DRAIN_CYCLES, then clear it and go GAP.
REQ-025 GAP SHALL hold both enables low for RESTART_GAP cycles, then go IDLE.
REQ-026 IDLE with a read request: app_address<=adr[21:0], expected<=adr, app_read_enable<=1, timeout counter cleared, go READ_WAIT.
REQ-027 READ_WAIT with read_fifo_empty=0: pulse app_read_pulse and go READ_POP.
REQ-028 READ_POP: wait one cycle.
REQ-029 READ_CAPTURE: if the request is still valid with adr==expected, wbs_dat_o<=app_read_data, ack, expected+=1, go READ_WAIT.
REQ-030 READ_CAPTURE: otherwise discard the word, clear app_read_enable and go GAP.
REQ-031 READ_WAIT while a request exists with adr!=expected, we=1, or cyc=0: clear app_read_enable and go GAP.
REQ-032 READ_WAIT reaching READ_TIMEOUT cycles without data: pulse wbs_err_o, clear app_read_enable, go GAP.
REQ-033 Simultaneous write_fifo_full deassert and cyc drop: the drop SHALL win; no push occurs.
REQ-034 sdram_ready falling in any state SHALL force both enables low and return to IDLE with no ack.

Reset
REQ-035 When rst=1: state=IDLE; all counters=0.
REQ-036 When rst=1: wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0.
REQ-037 When rst=1: app_write_enable=0, app_read_enable=0, app_write_pulse=0, app_read_pulse=0.
REQ-038 When rst=1: app_address=0, app_write_data=0, app_write_mask=0.
REQ-039 rst asserted mid-transfer SHALL abort the transfer without ack.

Verification
REQ-040 Write 3 words at 0x10,0x11,0x12, sel=F -> app_address=0x10, 3 pushes with mask=0, 3 acks; enable stays high 32 cycles after the last ack, then 4 cycles low.
REQ-041 Write at 0x10 then at 0x20 in the same cyc -> second write acked only after the drain+gap; second burst has app_address=0x20.
REQ-042 write_fifo_full held high 10 cycles during a write -> no ack or push during those cycles; ack follows 2 cycles after full drops.
REQ-043 Read 2 words at 0x3FFFFF with FIFO data A5A5A5A5, 5A5A5A5A -> wbs_dat_o matches in order; second word's expected address wraps to 0x000000.
REQ-044 Read with read_fifo_empty held high -> wbs_err_o pulse after 1024 cycles, app_read_enable cleared.
REQ-045 sdram_ready=0 with a pending write -> no ack and enables low; ack after sdram_ready rises.
